// File: rtl/inst_queue_if.sv
// Instruction queue bus bundle.
// Groups the fetch-side push port, the decode-side issue port and the flush
// request into one interface.
//   master : the surrounding pipeline. It drives flush, push and issue
//            controls and receives full/head data.
//   slave  : the queue itself.
// Fetch -> queue : push1_i, push2_i, f_inst{1,2}_i, f_addr{1,2}_i, f_bpu{1,2}_i
// Queue -> fetch : full_o
// Queue -> decode: inst{1,2}_o, inst{1,2}_addr_o, bpu_predict_info_o,
//                  issue_en_o, is_in_delayslot_o
// Decode -> queue: issued_i, issue_mode_i, ninst_in_delayslot_i
// Pipeline       : flush_i
interface inst_queue_if;
    logic        flush_i;
    logic        push1_i;
    logic        push2_i;
    logic [31:0] f_inst1_i;
    logic [31:0] f_inst2_i;
    logic [31:0] f_addr1_i;
    logic [31:0] f_addr2_i;
    logic [32:0] f_bpu1_i;
    logic [32:0] f_bpu2_i;
    logic        full_o;
    logic [31:0] inst1_o;
    logic [31:0] inst2_o;
    logic [31:0] inst1_addr_o;
    logic [31:0] inst2_addr_o;
    logic [32:0] bpu_predict_info_o;
    logic        issue_en_o;
    logic        is_in_delayslot_o;
    logic        issued_i;
    logic        issue_mode_i;
    logic        ninst_in_delayslot_i;

    modport master (
        output flush_i, push1_i, push2_i,
        output f_inst1_i, f_inst2_i, f_addr1_i, f_addr2_i, f_bpu1_i, f_bpu2_i,
        output issued_i, issue_mode_i, ninst_in_delayslot_i,
        input  full_o, inst1_o, inst2_o, inst1_addr_o, inst2_addr_o,
        input  bpu_predict_info_o, issue_en_o, is_in_delayslot_o
    );

    modport slave (
        input  flush_i, push1_i, push2_i,
        input  f_inst1_i, f_inst2_i, f_addr1_i, f_addr2_i, f_bpu1_i, f_bpu2_i,
        input  issued_i, issue_mode_i, ninst_in_delayslot_i,
        output full_o, inst1_o, inst2_o, inst1_addr_o, inst2_addr_o,
        output bpu_predict_info_o, issue_en_o, is_in_delayslot_o
    );
endinterface

// File: rtl/inst_queue.sv
// Dual-port instruction queue between fetch and the dual-issue decode stage.
// Accepts 0/1/2 instructions per cycle from fetch and retires 0/1/2 per cycle
// as decode issues them. The two oldest entries are presented combinationally.
// It also carries the delay-slot flag across single-issue boundaries.
// Ports:
//   clk : clock, rising edge
//   rst : asynchronous active-low reset
//   q   : inst_queue_if.slave (fetch push, decode issue, flush, head outputs)
// Parameters:
//   DEPTH : entry count, power of two, >= 4
//   PTR_W : log2(DEPTH)
module inst_queue #(
    parameter int DEPTH = 16,
    parameter int PTR_W = 4
) (
    input  logic          clk,
    input  logic          rst,
    inst_queue_if.slave   q
);
    localparam int CNT_W = PTR_W + 1;

    // Entry storage, split per field so every read port is fully used.
    logic [31:0] inst_mem [DEPTH];
    logic [31:0] addr_mem [DEPTH];
    logic [32:0] bpu_mem  [DEPTH];

    logic [PTR_W-1:0] rd_ptr_reg, rd_ptr_next;
    logic [PTR_W-1:0] wr_ptr_reg, wr_ptr_next;
    logic [CNT_W-1:0] count_reg, count_next;
    logic             ds_flag_reg, ds_flag_next;

    logic             full;
    logic [1:0]       push_n;
    logic [1:0]       pop_n;
    logic [PTR_W-1:0] wr_ptr_p1;
    logic [PTR_W-1:0] rd_ptr_p1;
    logic             has_one;
    logic             has_two;

    // Pointers are PTR_W bits wide, so +1 wraps modulo DEPTH for free.
    assign wr_ptr_p1 = wr_ptr_reg + PTR_W'(1);
    assign rd_ptr_p1 = rd_ptr_reg + PTR_W'(1);

    // Fetch holds whenever fewer than two slots are free, so a pair always fits.
    assign full    = count_reg >= CNT_W'(DEPTH - 1);
    assign has_one = count_reg != '0;
    assign has_two = count_reg >= CNT_W'(2);

    always_comb begin
        push_n       = 2'd0;
        pop_n        = 2'd0;
        rd_ptr_next  = rd_ptr_reg;
        wr_ptr_next  = wr_ptr_reg;
        count_next   = count_reg;
        ds_flag_next = ds_flag_reg;

        // Push decision uses the pre-pop count; slot 2 rides only on slot 1.
        if (q.push1_i && !full) begin
            push_n = q.push2_i ? 2'd2 : 2'd1;
        end

        // Dual issue with a single entry left retires just that entry.
        if (q.issued_i && has_one) begin
            pop_n = (q.issue_mode_i && has_two) ? 2'd2 : 2'd1;
        end

        if (q.flush_i) begin
            rd_ptr_next  = '0;
            wr_ptr_next  = '0;
            count_next   = '0;
            ds_flag_next = 1'b0;
        end else begin
            rd_ptr_next = rd_ptr_reg + PTR_W'(pop_n);
            wr_ptr_next = wr_ptr_reg + PTR_W'(push_n);
            count_next  = count_reg + CNT_W'(push_n) - CNT_W'(pop_n);
            // A dual issue takes a branch together with its slot, so the
            // flag only survives a single issue, and then as decode reports it.
            if (pop_n != 2'd0) begin
                ds_flag_next = q.issue_mode_i ? 1'b0 : q.ninst_in_delayslot_i;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr_reg  <= '0;
            wr_ptr_reg  <= '0;
            count_reg   <= '0;
            ds_flag_reg <= 1'b0;
        end else begin
            rd_ptr_reg  <= rd_ptr_next;
            wr_ptr_reg  <= wr_ptr_next;
            count_reg   <= count_next;
            ds_flag_reg <= ds_flag_next;
        end
    end

    // Contents need no reset: count gates every output. Flush drops the
    // same-cycle push so nothing stale is written behind the reset pointers.
    always_ff @(posedge clk) begin
        if (!q.flush_i) begin
            if (push_n != 2'd0) begin
                inst_mem[wr_ptr_reg] <= q.f_inst1_i;
                addr_mem[wr_ptr_reg] <= q.f_addr1_i;
                bpu_mem[wr_ptr_reg]  <= q.f_bpu1_i;
            end
            if (push_n == 2'd2) begin
                inst_mem[wr_ptr_p1] <= q.f_inst2_i;
                addr_mem[wr_ptr_p1] <= q.f_addr2_i;
                bpu_mem[wr_ptr_p1]  <= q.f_bpu2_i;
            end
        end
    end

    // Head outputs read straight from storage; a push shows up one cycle later.
    assign q.inst1_o            = has_one ? inst_mem[rd_ptr_reg] : 32'd0;
    assign q.inst1_addr_o       = has_one ? addr_mem[rd_ptr_reg] : 32'd0;
    assign q.bpu_predict_info_o = has_one ? bpu_mem[rd_ptr_reg]  : 33'd0;
    assign q.inst2_o            = has_two ? inst_mem[rd_ptr_p1]  : 32'd0;
    assign q.inst2_addr_o       = has_two ? addr_mem[rd_ptr_p1]  : 32'd0;
    assign q.issue_en_o         = has_one;
    assign q.full_o             = full;
    assign q.is_in_delayslot_o  = ds_flag_reg;
endmodule

// File: tb/tb_inst_queue.sv
module tb_inst_queue;
    logic clk;
    logic rst;
    int   pass_cnt;
    int   total_cnt;

    inst_queue_if q_if ();

    inst_queue #(.DEPTH(16), .PTR_W(4)) dut (
        .clk (clk),
        .rst (rst),
        .q   (q_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        q_if.flush_i = 0; q_if.push1_i = 0; q_if.push2_i = 0;
        q_if.f_inst1_i = 0; q_if.f_inst2_i = 0; q_if.f_addr1_i = 0; q_if.f_addr2_i = 0;
        q_if.f_bpu1_i = 0; q_if.f_bpu2_i = 0;
        q_if.issued_i = 0; q_if.issue_mode_i = 0; q_if.ninst_in_delayslot_i = 0;
    endtask

    task automatic push_one(input logic [31:0] i1, input logic [31:0] a1, input logic [32:0] b1);
        q_if.push1_i = 1; q_if.push2_i = 0;
        q_if.f_inst1_i = i1; q_if.f_addr1_i = a1; q_if.f_bpu1_i = b1;
        tick();
        q_if.push1_i = 0;
    endtask

    task automatic push_pair(input logic [31:0] i1, input logic [31:0] a1,
                             input logic [31:0] i2, input logic [31:0] a2);
        q_if.push1_i = 1; q_if.push2_i = 1;
        q_if.f_inst1_i = i1; q_if.f_addr1_i = a1; q_if.f_bpu1_i = {1'b1, a1};
        q_if.f_inst2_i = i2; q_if.f_addr2_i = a2; q_if.f_bpu2_i = {1'b1, a2};
        tick();
        q_if.push1_i = 0; q_if.push2_i = 0;
    endtask

    task automatic issue(input logic mode, input logic ninst);
        q_if.issued_i = 1; q_if.issue_mode_i = mode; q_if.ninst_in_delayslot_i = ninst;
        tick();
        q_if.issued_i = 0; q_if.issue_mode_i = 0; q_if.ninst_in_delayslot_i = 0;
    endtask

    task automatic do_flush();
        q_if.flush_i = 1;
        tick();
        q_if.flush_i = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 0;
        #12;
        total_cnt++; if (q_if.issue_en_o !== 1'b0) $display("FAIL rst_issue_en got %b exp 0", q_if.issue_en_o); else pass_cnt++;
        total_cnt++; if (q_if.full_o !== 1'b0) $display("FAIL rst_full got %b exp 0", q_if.full_o); else pass_cnt++;
        #2 rst = 1;
        tick(); tick();
        total_cnt++; if (q_if.inst1_o !== 32'd0) $display("FAIL idle_inst1 got %h exp 0", q_if.inst1_o); else pass_cnt++;
        total_cnt++; if (q_if.inst2_o !== 32'd0) $display("FAIL idle_inst2 got %h exp 0", q_if.inst2_o); else pass_cnt++;
        total_cnt++; if (q_if.is_in_delayslot_o !== 1'b0) $display("FAIL idle_ds got %b exp 0", q_if.is_in_delayslot_o); else pass_cnt++;
        total_cnt++; if (q_if.issue_en_o !== 1'b0) $display("FAIL idle_issue_en got %b exp 0", q_if.issue_en_o); else pass_cnt++;
        push_pair(32'h24010001, 32'hBFC00000, 32'h24020002, 32'hBFC00004);
        total_cnt++; if (q_if.issue_en_o !== 1'b1) $display("FAIL pair_issue_en got %b exp 1", q_if.issue_en_o); else pass_cnt++;
        total_cnt++; if (q_if.inst1_o !== 32'h24010001) $display("FAIL pair_inst1 got %h exp 24010001", q_if.inst1_o); else pass_cnt++;
        total_cnt++; if (q_if.inst2_o !== 32'h24020002) $display("FAIL pair_inst2 got %h exp 24020002", q_if.inst2_o); else pass_cnt++;
        total_cnt++; if (q_if.inst1_addr_o !== 32'hBFC00000) $display("FAIL pair_addr1 got %h exp bfc00000", q_if.inst1_addr_o); else pass_cnt++;
        total_cnt++; if (q_if.inst2_addr_o !== 32'hBFC00004) $display("FAIL pair_addr2 got %h exp bfc00004", q_if.inst2_addr_o); else pass_cnt++;
        total_cnt++; if (q_if.bpu_predict_info_o !== 33'h1BFC00000) $display("FAIL pair_bpu got %h exp 1bfc00000", q_if.bpu_predict_info_o); else pass_cnt++;
        $display("test_reset done");
    endtask

    task automatic test_pop_modes();
        do_flush();
        push_pair(32'hA, 32'h100, 32'hB, 32'h104);
        push_pair(32'hC, 32'h108, 32'hD, 32'h10C);
        issue(1'b0, 1'b0);
        total_cnt++; if (q_if.inst1_o !== 32'hB) $display("FAIL single_pop_inst1 got %h exp b", q_if.inst1_o); else pass_cnt++;
        total_cnt++; if (q_if.inst1_addr_o !== 32'h104) $display("FAIL single_pop_addr1 got %h exp 104", q_if.inst1_addr_o); else pass_cnt++;
        total_cnt++; if (q_if.inst2_o !== 32'hC) $display("FAIL single_pop_inst2 got %h exp c", q_if.inst2_o); else pass_cnt++;
        issue(1'b1, 1'b0);
        total_cnt++; if (q_if.inst1_o !== 32'hD) $display("FAIL dual_pop_inst1 got %h exp d", q_if.inst1_o); else pass_cnt++;
        total_cnt++; if (q_if.inst1_addr_o !== 32'h10C) $display("FAIL dual_pop_addr1 got %h exp 10c", q_if.inst1_addr_o); else pass_cnt++;
        total_cnt++; if (q_if.inst2_o !== 32'd0) $display("FAIL dual_pop_inst2 got %h exp 0", q_if.inst2_o); else pass_cnt++;
        total_cnt++; if (q_if.inst2_addr_o !== 32'd0) $display("FAIL dual_pop_addr2 got %h exp 0", q_if.inst2_addr_o); else pass_cnt++;
        issue(1'b1, 1'b0);
        total_cnt++; if (q_if.issue_en_o !== 1'b0) $display("FAIL dual_clamp_issue_en got %b exp 0", q_if.issue_en_o); else pass_cnt++;
        total_cnt++; if (q_if.inst1_o !== 32'd0) $display("FAIL dual_clamp_inst1 got %h exp 0", q_if.inst1_o); else pass_cnt++;
        $display("test_pop_modes done");
    endtask

    // Leaves rd_ptr = wr_ptr = 15 with the queue empty for the wrap test.
    task automatic test_full();
        do_flush();
        for (int k = 0; k < 14; k += 2)
            push_pair(32'h1000 + k, 32'h300 + 4*k, 32'h1000 + k + 1, 32'h300 + 4*(k+1));
        total_cnt++; if (q_if.full_o !== 1'b0) $display("FAIL full_at14 got %b exp 0", q_if.full_o); else pass_cnt++;
        push_one(32'h100E, 32'h338, 33'd14);
        total_cnt++; if (q_if.full_o !== 1'b1) $display("FAIL full_at15 got %b exp 1", q_if.full_o); else pass_cnt++;
        push_pair(32'hDEAD0001, 32'h900, 32'hDEAD0002, 32'h904);
        total_cnt++; if (q_if.full_o !== 1'b1) $display("FAIL full_after_drop got %b exp 1", q_if.full_o); else pass_cnt++;
        issue(1'b1, 1'b0);
        total_cnt++; if (q_if.full_o !== 1'b0) $display("FAIL full_at13 got %b exp 0", q_if.full_o); else pass_cnt++;
        total_cnt++; if (q_if.inst1_o !== 32'h1002) $display("FAIL full_pop_inst1 got %h exp 1002", q_if.inst1_o); else pass_cnt++;
        total_cnt++; if (q_if.inst2_o !== 32'h1003) $display("FAIL full_pop_inst2 got %h exp 1003", q_if.inst2_o); else pass_cnt++;
        for (int k = 0; k < 6; k++) issue(1'b1, 1'b0);
        total_cnt++; if (q_if.inst1_o !== 32'h100E) $display("FAIL drain_last_inst1 got %h exp 100e", q_if.inst1_o); else pass_cnt++;
        total_cnt++; if (q_if.inst2_o !== 32'd0) $display("FAIL drain_no_dropped got %h exp 0", q_if.inst2_o); else pass_cnt++;
        total_cnt++; if (q_if.bpu_predict_info_o !== 33'd14) $display("FAIL drain_bpu got %h exp e", q_if.bpu_predict_info_o); else pass_cnt++;
        issue(1'b0, 1'b0);
        total_cnt++; if (q_if.issue_en_o !== 1'b0) $display("FAIL drain_empty got %b exp 0", q_if.issue_en_o); else pass_cnt++;
        $display("test_full done");
    endtask

    task automatic test_wrap();
        push_pair(32'h58, 32'h200, 32'h59, 32'h204);
        total_cnt++; if (q_if.inst1_o !== 32'h58) $display("FAIL wrap_inst1 got %h exp 58", q_if.inst1_o); else pass_cnt++;
        total_cnt++; if (q_if.inst2_o !== 32'h59) $display("FAIL wrap_inst2 got %h exp 59", q_if.inst2_o); else pass_cnt++;
        total_cnt++; if (q_if.inst1_addr_o !== 32'h200) $display("FAIL wrap_addr1 got %h exp 200", q_if.inst1_addr_o); else pass_cnt++;
        total_cnt++; if (q_if.inst2_addr_o !== 32'h204) $display("FAIL wrap_addr2 got %h exp 204", q_if.inst2_addr_o); else pass_cnt++;
        issue(1'b1, 1'b0);
        total_cnt++; if (q_if.issue_en_o !== 1'b0) $display("FAIL wrap_empty got %b exp 0", q_if.issue_en_o); else pass_cnt++;
        push_one(32'h5A, 32'h208, 33'd5);
        total_cnt++; if (q_if.inst1_o !== 32'h5A) $display("FAIL wrap_next_inst1 got %h exp 5a", q_if.inst1_o); else pass_cnt++;
        $display("test_wrap done");
    endtask

    task automatic test_delay_slot();
        do_flush();
        push_pair(32'h1, 32'h400, 32'h2, 32'h404);
        push_pair(32'h3, 32'h408, 32'h4, 32'h40C);
        push_pair(32'h5, 32'h410, 32'h6, 32'h414);
        issue(1'b0, 1'b1);
        total_cnt++; if (q_if.is_in_delayslot_o !== 1'b1) $display("FAIL ds_set got %b exp 1", q_if.is_in_delayslot_o); else pass_cnt++;
        issue(1'b0, 1'b0);
        total_cnt++; if (q_if.is_in_delayslot_o !== 1'b0) $display("FAIL ds_clear_single got %b exp 0", q_if.is_in_delayslot_o); else pass_cnt++;
        issue(1'b0, 1'b1);
        tick();
        total_cnt++; if (q_if.is_in_delayslot_o !== 1'b1) $display("FAIL ds_hold_idle got %b exp 1", q_if.is_in_delayslot_o); else pass_cnt++;
        issue(1'b1, 1'b1);
        total_cnt++; if (q_if.is_in_delayslot_o !== 1'b0) $display("FAIL ds_clear_dual got %b exp 0", q_if.is_in_delayslot_o); else pass_cnt++;
        total_cnt++; if (q_if.inst1_o !== 32'h6) $display("FAIL ds_head got %h exp 6", q_if.inst1_o); else pass_cnt++;
        issue(1'b0, 1'b1);
        issue(1'b0, 1'b0);
        total_cnt++; if (q_if.is_in_delayslot_o !== 1'b1) $display("FAIL ds_hold_empty got %b exp 1", q_if.is_in_delayslot_o); else pass_cnt++;
        do_flush();
        total_cnt++; if (q_if.is_in_delayslot_o !== 1'b0) $display("FAIL ds_flush got %b exp 0", q_if.is_in_delayslot_o); else pass_cnt++;
        $display("test_delay_slot done");
    endtask

    task automatic test_flush();
        push_pair(32'h11, 32'h500, 32'h12, 32'h504);
        push_pair(32'h13, 32'h508, 32'h14, 32'h50C);
        issue(1'b0, 1'b1);
        q_if.flush_i = 1; q_if.issued_i = 1; q_if.issue_mode_i = 1;
        q_if.push1_i = 1; q_if.push2_i = 1;
        q_if.f_inst1_i = 32'hEE1; q_if.f_inst2_i = 32'hEE2;
        tick();
        idle_inputs();
        total_cnt++; if (q_if.issue_en_o !== 1'b0) $display("FAIL flush_issue_en got %b exp 0", q_if.issue_en_o); else pass_cnt++;
        total_cnt++; if (q_if.is_in_delayslot_o !== 1'b0) $display("FAIL flush_ds got %b exp 0", q_if.is_in_delayslot_o); else pass_cnt++;
        total_cnt++; if (q_if.inst1_o !== 32'd0) $display("FAIL flush_inst1 got %h exp 0", q_if.inst1_o); else pass_cnt++;
        push_one(32'h77, 32'h600, 33'd7);
        total_cnt++; if (q_if.inst1_o !== 32'h77) $display("FAIL post_flush_inst1 got %h exp 77", q_if.inst1_o); else pass_cnt++;
        total_cnt++; if (q_if.inst2_o !== 32'd0) $display("FAIL post_flush_inst2 got %h exp 0", q_if.inst2_o); else pass_cnt++;
        $display("test_flush done");
    endtask

    task automatic test_async_reset();
        push_pair(32'h21, 32'h700, 32'h22, 32'h704);
        issue(1'b0, 1'b1);
        total_cnt++; if (q_if.issue_en_o !== 1'b1) $display("FAIL pre_rst_issue_en got %b exp 1", q_if.issue_en_o); else pass_cnt++;
        #2 rst = 0;
        #1;
        total_cnt++; if (q_if.issue_en_o !== 1'b0) $display("FAIL async_rst_issue_en got %b exp 0", q_if.issue_en_o); else pass_cnt++;
        total_cnt++; if (q_if.inst1_o !== 32'd0) $display("FAIL async_rst_inst1 got %h exp 0", q_if.inst1_o); else pass_cnt++;
        total_cnt++; if (q_if.is_in_delayslot_o !== 1'b0) $display("FAIL async_rst_ds got %b exp 0", q_if.is_in_delayslot_o); else pass_cnt++;
        #1 rst = 1;
        tick();
        total_cnt++; if (q_if.issue_en_o !== 1'b0) $display("FAIL post_rst_issue_en got %b exp 0", q_if.issue_en_o); else pass_cnt++;
        $display("test_async_reset done");
    endtask

    initial begin
        pass_cnt = 0;
        total_cnt = 0;
        rst = 1;
        idle_inputs();
        test_reset();
        test_pop_modes();
        test_full();
        test_wrap();
        test_delay_slot();
        test_flush();
        test_async_reset();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule

// File: doc/inst_queue.md
Name: inst_queue

Overview:
- Dual-port instruction queue between the fetch/icache stage and the dual-issue decode stage.
- Accepts up to two fetched instructions per cycle, each with its PC and 33-bit branch-prediction info.
- Presents the two oldest entries to decode and retires 0, 1 or 2 entries per cycle according to decode's issue decision.
- Tracks the delay-slot flag across single-issue boundaries. Clears on pipeline flush.

Parameters:
- DEPTH, 16, number of entries; power of two, >= 4.
- PTR_W, 4, log2(DEPTH); pointer width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset (0 = reset).
- flush_i  in  1  discard all entries and delay-slot state (exception or branch redirect).
- push1_i  in  1  fetch slot 1 valid.
- push2_i  in  1  fetch slot 2 valid; only meaningful when push1_i=1.
- f_inst1_i  in  32  slot-1 instruction.
- f_inst2_i  in  32  slot-2 instruction.
- f_addr1_i  in  32  slot-1 PC.
- f_addr2_i  in  32  slot-2 PC.
- f_bpu1_i  in  33  slot-1 prediction info.
- f_bpu2_i  in  33  slot-2 prediction info.
- full_o  out  1  fewer than 2 free entries; fetch must hold.
- inst1_o  out  32  head entry instruction (0 if empty).
- inst2_o  out  32  head+1 instruction (0 if count<2).
- inst1_addr_o  out  32  head PC (0 if empty).
- inst2_addr_o  out  32  head+1 PC (0 if count<2).
- bpu_predict_info_o  out  33  head entry prediction info (0 if empty).
- issue_en_o  out  1  count>=1.
- is_in_delayslot_o  out  1  head entry is a delay-slot instruction.
- issued_i  in  1  decode consumed this cycle.
- issue_mode_i  in  1  1 = dual issue (pop 2), 0 = single issue (pop 1).
- ninst_in_delayslot_i  in  1  from decode: next unissued instruction is in a delay slot (valid on single issue).

Behaviour:
- Storage: circular array of DEPTH entries {inst, addr, bpu}; head pointer rd_ptr, tail pointer wr_ptr, occupancy count (PTR_W+1 bits). Pointers wrap modulo DEPTH.
- Reset (rst=0, async): rd_ptr=wr_ptr=0, count=0, ds_flag=0. Outputs are zero, issue_en_o=0 and full_o=0. Entry contents are don't-care.
- full_o = (DEPTH - count) < 2. Combinational from registered count.
- Push is evaluated on the pre-pop count.
  - Accepted only when full_o=0.
  - push1_i alone writes slot 1 at wr_ptr; wr_ptr+=1.
  - push1_i and push2_i write slot 1 at wr_ptr and slot 2 at wr_ptr+1; wr_ptr+=2.
  - push2_i without push1_i is ignored.
  - Push while full_o=1 is dropped. Assertion: fetch never does this.
- Pop amount:
  - n = 0 if issued_i=0 or count=0.
  - Otherwise n = issue_mode_i ? 2 : 1, clamped to count (dual with count=1 pops 1).
  - rd_ptr+=n.
- Simultaneous push and pop in the same cycle: count_next = count + pushed - n. A pushed entry is never visible at the outputs in its write cycle; there is no bypass and output latency is 1 cycle.
- Outputs are combinational reads at rd_ptr and rd_ptr+1 (wrapped), gated by count.
- Delay slot:
  - is_in_delayslot_o = ds_flag.
  - On issued_i with n>0: ds_flag_next = (issue_mode_i=0) ? ninst_in_delayslot_i : 0.
  - A dual issue consumes the branch and its slot together, so the flag clears.
  - With no issue, ds_flag holds.
- Flush has priority over push and pop in the same cycle: rd_ptr=wr_ptr=0, count=0, ds_flag=0. Same-cycle push data is discarded.
- Reset mid-operation takes effect immediately, asynchronously. No partial entry survives it.
- Wrap-around: a dual pop or dual push straddling index DEPTH-1 to 0 must read/write both entries correctly.

Test Plan:
- Reset then idle → count=0, issue_en_o=0, full_o=0, inst1_o=0, inst2_o=0. Push pair {0x24010001 @0xBFC00000, 0x24020002 @0xBFC00004} → next cycle issue_en_o=1 with those values on inst1_o/inst2_o and addresses.
- Push 4 insts (A@0x100..D@0x10C). issued_i=1, mode=0 → head becomes B@0x104. Next cycle issued_i=1, mode=1 → head D@0x10C; inst2_o=0 (count=1).
- Fill to 15 entries → full_o=1; push attempt ignored; count stays 15. Dual pop → count=13, full_o=0.
- Wrap: advance pointers to rd=wr=15, push pair X@0x200, Y@0x204 → stored at indices 15 and 0. Dual pop → returns X then Y in order; count=0.
- Delay slot: single issue with ninst_in_delayslot_i=1 → is_in_delayslot_o=1 next cycle. Next single issue with ninst=0 → 0. Dual issue with flag=1 → cleared.
- Flush with simultaneous push2 and issued_i → next cycle count=0, issue_en_o=0, ds_flag=0. Async rst pulse mid-stream → outputs zero before the next clock edge.
